// File: rtl/gpio_mmio_ctrl_if.sv
// gpio_mmio_ctrl_if: byte-wide CPU data-bus port (write strobe, address, write data, registered read data)
interface gpio_mmio_ctrl_if #(parameter int ADDR_W = 9);
  logic              rw_select;
  logic [ADDR_W-1:0] address;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  modport master (output rw_select, address, data_in, input data_out);
  modport slave (input rw_select, address, data_in, output data_out);
endinterface

// File: rtl/gpio_mmio_ctrl.sv
// gpio_mmio_ctrl: byte RAM with a 16-byte GPIO window at the top; defining GPIO_IRQ_EN adds IRQ_MASK and the irq output
module gpio_mmio_ctrl #(
  parameter int DEPTH           = 512,
  parameter int ADDR_W          = $clog2(DEPTH),
  parameter int NUM_BTN         = 4,
  parameter int NUM_SW          = 16,
  parameter int NUM_LED         = 16,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter     INIT_FILE       = "fib_test.dat"
) (
  input  logic                    clk,
  input  logic                    reset,
  gpio_mmio_ctrl_if.slave         bus,
  input  logic [NUM_BTN-1:0]      buttons,
  input  logic [NUM_SW-1:0]       switches,
  output logic [NUM_LED-1:0]      leds,
  output logic [4*NUM_DIGITS-1:0] digits
`ifdef GPIO_IRQ_EN
  , output logic                  irq
`endif
);
  localparam int IO_BASE = DEPTH - 16;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [7:0] mem [IO_BASE];
  logic io_sel, wr_io;
  logic [3:0] off;
  logic [7:0] io_rd;
  logic [15:0] sw_ext, led_cat;
  logic [NUM_BTN-1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [NUM_SW-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [NUM_BTN-1:0] btn_state_q, btn_state_d, btn_edge_q, btn_edge_d, edge_clr;
  logic [NUM_BTN-1:0][CW-1:0] cnt_q, cnt_d;
  logic [7:0] led_lo_q, led_lo_d, led_hi_q, led_hi_d, dout_q, dout_d;
  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [NUM_LED-1:0] leds_q, leds_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
`ifdef GPIO_IRQ_EN
  logic [NUM_BTN-1:0] irq_mask_q, irq_mask_d;
  logic irq_q, irq_d;
`endif

  // IO_BASE is a multiple of 16, so the window is exactly the all-ones upper address bits
  assign io_sel = &bus.address[ADDR_W-1:4];
  assign off = bus.address[3:0];
  assign wr_io = bus.rw_select & io_sel;
  assign sw_ext = 16'(sw_s2_q);
  assign led_cat = {led_hi_q, led_lo_q};

  always_ff @(posedge clk)
    if (bus.rw_select && !io_sel) mem[bus.address] <= bus.data_in;

  always_comb begin
    io_rd = '0;
    case (off)
      4'd0: io_rd = 8'(btn_state_q);
      4'd1: io_rd = 8'(btn_edge_q);
      4'd2: io_rd = sw_ext[7:0];
      4'd3: io_rd = sw_ext[15:8];
      4'd4: io_rd = led_lo_q;
      4'd5: io_rd = led_hi_q;
`ifdef GPIO_IRQ_EN
      4'd14: io_rd = 8'(irq_mask_q);
`endif
      default: io_rd = '0;
    endcase
    for (int n = 0; n < NUM_DIGITS; n++)
      if (off == 4'(6 + n)) io_rd = {4'h0, digit_q[n]};
  end

  always_comb begin
    btn_s1_d = buttons;
    btn_s2_d = btn_s1_q;
    sw_s1_d = switches;
    sw_s2_d = sw_s1_q;
    btn_state_d = btn_state_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_BTN; i++)
      if (btn_s2_q[i] == btn_state_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_d[i] = '0;
        btn_state_d[i] = btn_s2_q[i];
      end else cnt_d[i] = cnt_q[i] + 1'b1;
    // a rising edge in the same cycle as a W1C clear keeps the bit set
    edge_clr = (wr_io && off == 4'd1) ? bus.data_in[NUM_BTN-1:0] : '0;
    btn_edge_d = (btn_edge_q & ~edge_clr) | (btn_state_d & ~btn_state_q);
    led_lo_d = (wr_io && off == 4'd4) ? bus.data_in : led_lo_q;
    led_hi_d = (wr_io && off == 4'd5) ? bus.data_in : led_hi_q;
    digit_d = digit_q;
    for (int n = 0; n < NUM_DIGITS; n++)
      if (wr_io && off == 4'(6 + n)) digit_d[n] = bus.data_in[3:0];
    leds_d = led_cat[NUM_LED-1:0];
    digits_d = digit_q;
    dout_d = io_sel ? io_rd : mem[bus.address];
`ifdef GPIO_IRQ_EN
    irq_mask_d = (wr_io && off == 4'd14) ? bus.data_in[NUM_BTN-1:0] : irq_mask_q;
    irq_d = |(btn_edge_q & irq_mask_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      btn_state_q <= '0;
      btn_edge_q <= '0;
      cnt_q <= '0;
      led_lo_q <= '0;
      led_hi_q <= '0;
      digit_q <= '0;
      leds_q <= '0;
      digits_q <= '0;
      dout_q <= '0;
`ifdef GPIO_IRQ_EN
      irq_mask_q <= '0;
      irq_q <= 1'b0;
`endif
    end else begin
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      btn_state_q <= btn_state_d;
      btn_edge_q <= btn_edge_d;
      cnt_q <= cnt_d;
      led_lo_q <= led_lo_d;
      led_hi_q <= led_hi_d;
      digit_q <= digit_d;
      leds_q <= leds_d;
      digits_q <= digits_d;
      dout_q <= dout_d;
`ifdef GPIO_IRQ_EN
      irq_mask_q <= irq_mask_d;
      irq_q <= irq_d;
`endif
    end
  end

  assign bus.data_out = dout_q;
  assign leds = leds_q;
  assign digits = digits_q;
`ifdef GPIO_IRQ_EN
  assign irq = irq_q;
`endif
endmodule

// File: tb/tb_gpio_mmio_ctrl.sv
// tb_gpio_mmio_ctrl: directed vector table, hand sequences and random traffic checked against a behavioural model
module tb_gpio_mmio_ctrl;
  localparam int DEPTH = 512, AW = 9, NB = 4, NS = 16, NL = 16, ND = 4, DB = 4;
  localparam int IO_BASE = DEPTH - 16;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [NB-1:0] buttons;
  logic [NS-1:0] switches;
  logic [NL-1:0] leds;
  logic [4*ND-1:0] digits;
  logic irq;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  gpio_mmio_ctrl_if #(.ADDR_W(AW)) bus ();

  gpio_mmio_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(AW), .NUM_BTN(NB), .NUM_SW(NS), .NUM_LED(NL),
    .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .buttons(buttons), .switches(switches),
    .leds(leds), .digits(digits)
`ifdef GPIO_IRQ_EN
    , .irq(irq)
`endif
  );
`ifndef GPIO_IRQ_EN
  assign irq = 1'b0;
`endif

  // behavioural model state
  logic [7:0] m_ram [IO_BASE];
  bit m_vld [IO_BASE];
  logic [NB-1:0] m_state, m_edge, m_mask;
  int m_mism [NB];
  logic [7:0] m_led_lo, m_led_hi, m_dout;
  logic [3:0] m_dig [ND];
  logic [NL-1:0] m_leds;
  logic [4*ND-1:0] m_digits;
  logic m_irq;
  bit m_dout_vld;
  logic [NB-1:0] bq [$];
  logic [NS-1:0] sq [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic [NB-1:0] bs, ns, clr;
    logic [NS-1:0] ss;
    logic [15:0] swx, lc;
    int off, a;
    bit io;
    if (reset) begin
      m_state = '0; m_edge = '0; m_mask = '0; m_led_lo = '0; m_led_hi = '0;
      m_leds = '0; m_digits = '0; m_irq = 1'b0; m_dout = '0; m_dout_vld = 1'b1;
      for (int i = 0; i < NB; i++) m_mism[i] = 0;
      for (int n = 0; n < ND; n++) m_dig[n] = '0;
      bq.delete();
      sq.delete();
      return;
    end
    bs = (bq.size() == 2) ? bq[0] : '0;
    ss = (sq.size() == 2) ? sq[0] : '0;
    a = int'(bus.address);
    io = a >= IO_BASE;
    off = a - IO_BASE;
    swx = 16'(ss);
    if (!io) begin
      m_dout = m_ram[a];
      m_dout_vld = m_vld[a];
    end else begin
      m_dout_vld = 1'b1;
      m_dout = 8'h00;
      if (off == 0) m_dout = 8'(m_state);
      if (off == 1) m_dout = 8'(m_edge);
      if (off == 2) m_dout = swx[7:0];
      if (off == 3) m_dout = swx[15:8];
      if (off == 4) m_dout = m_led_lo;
      if (off == 5) m_dout = m_led_hi;
      if (off >= 6 && off < 6 + ND) m_dout = {4'h0, m_dig[off-6]};
      if (off == 14 && IRQ_EN) m_dout = 8'(m_mask);
    end
    lc = {m_led_hi, m_led_lo};
    m_leds = lc[NL-1:0];
    for (int n = 0; n < ND; n++) m_digits[4*n +: 4] = m_dig[n];
    m_irq = |(m_edge & m_mask);
    ns = m_state;
    for (int i = 0; i < NB; i++)
      if (bs[i] != m_state[i]) begin
        m_mism[i]++;
        if (m_mism[i] == DB) begin
          ns[i] = bs[i];
          m_mism[i] = 0;
        end
      end else m_mism[i] = 0;
    clr = (io && bus.rw_select && off == 1) ? bus.data_in[NB-1:0] : '0;
    m_edge = (m_edge & ~clr) | (ns & ~m_state);
    m_state = ns;
    if (bus.rw_select) begin
      if (!io) begin
        m_ram[a] = bus.data_in;
        m_vld[a] = 1'b1;
      end
      if (io && off == 4) m_led_lo = bus.data_in;
      if (io && off == 5) m_led_hi = bus.data_in;
      if (io && off >= 6 && off < 6 + ND) m_dig[off-6] = bus.data_in[3:0];
      if (io && off == 14 && IRQ_EN) m_mask = bus.data_in[NB-1:0];
    end
    bq.push_back(buttons);
    sq.push_back(switches);
    if (bq.size() > 2) void'(bq.pop_front());
    if (sq.size() > 2) void'(sq.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_dout_vld) chk("model_data_out", 32'(bus.data_out), 32'(m_dout));
    chk("model_leds", 32'(leds), 32'(m_leds));
    chk("model_digits", 32'(digits), 32'(m_digits));
    chk("model_irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic drive(input logic r, input logic w, input int a, input logic [7:0] d);
    reset = r;
    bus.rw_select = w;
    bus.address = AW'(a);
    bus.data_in = d;
    tick();
  endtask

  typedef struct {
    logic rst; logic rw; int addr; logic [7:0] din; logic [15:0] sw; bit chk; logic [7:0] exp;
  } vec_t;
  vec_t tbl [$];

  initial begin
    for (int a = 0; a < IO_BASE; a++) m_vld[a] = 1'b0;
    buttons = '0;
    switches = '0;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int a = 0; a < IO_BASE; a++) drive(0, 1, a, 8'($urandom));

    tbl.push_back('{1, 0, 0,     8'h00, 16'h0000, 1, 8'h00});
    tbl.push_back('{0, 1, 10,    8'hA5, 16'h0000, 0, 8'h00});
    tbl.push_back('{0, 0, 10,    8'h00, 16'h0000, 1, 8'hA5});
    tbl.push_back('{0, 1, 10,    8'h5A, 16'h0000, 1, 8'hA5});
    tbl.push_back('{0, 0, 10,    8'h00, 16'h0000, 1, 8'h5A});
    tbl.push_back('{0, 1, 'h1F2, 8'hFF, 16'h1234, 0, 8'h00});
    tbl.push_back('{0, 0, 'h1F2, 8'h00, 16'h1234, 0, 8'h00});
    tbl.push_back('{0, 0, 'h1F2, 8'h00, 16'h1234, 1, 8'h34});
    tbl.push_back('{0, 0, 'h1F3, 8'h00, 16'h1234, 1, 8'h12});
    tbl.push_back('{0, 1, 'h1F4, 8'h3C, 16'h1234, 0, 8'h00});
    tbl.push_back('{0, 1, 'h1F5, 8'h81, 16'h1234, 0, 8'h00});
    tbl.push_back('{0, 1, 'h1F6, 8'hF7, 16'h1234, 1, 8'h00});
    tbl.push_back('{0, 0, 'h1F6, 8'h00, 16'h1234, 1, 8'h07});
    tbl.push_back('{0, 0, 'h1F4, 8'h00, 16'h1234, 1, 8'h3C});
    tbl.push_back('{0, 1, 'h1FF, 8'hAB, 16'h1234, 1, 8'h00});
    tbl.push_back('{0, 0, 'h1FF, 8'h00, 16'h1234, 1, 8'h00});
    tbl.push_back('{0, 1, 'h1FE, 8'hFF, 16'h1234, 0, 8'h00});
    tbl.push_back('{0, 0, 'h1FE, 8'h00, 16'h1234, 1, IRQ_EN ? 8'h0F : 8'h00});
    tbl.push_back('{0, 1, 'h1F0, 8'hFF, 16'h1234, 1, 8'h00});
    tbl.push_back('{0, 0, 'h1F0, 8'h00, 16'h1234, 1, 8'h00});
    for (int i = 0; i < tbl.size(); i++) begin
      switches = tbl[i].sw;
      drive(tbl[i].rst, tbl[i].rw, tbl[i].addr, tbl[i].din);
      if (tbl[i].chk) chk($sformatf("vec%0d_data_out", i), 32'(bus.data_out), 32'(tbl[i].exp));
    end
    chk("leds_813c", 32'(leds), 32'h813C);
    chk("digit0_7", 32'(digits[3:0]), 32'h7);

    drive(1, 0, 0, 0);
    drive(0, 0, 10, 0);
    chk("ram_kept_reset", 32'(bus.data_out), 32'h5A);
    chk("leds_reset", 32'(leds), 32'h0);
    chk("digits_reset", 32'(digits), 32'h0);

    buttons = 4'h1;
    for (int k = 0; k < 3; k++) drive(0, 0, 'h1F0, 0);
    buttons = 4'h0;
    for (int k = 0; k < 8; k++) drive(0, 0, 'h1F0, 0);
    chk("short_pulse_state", 32'(bus.data_out), 32'h0);
    buttons = 4'h1;
    for (int k = 0; k < 6; k++) drive(0, 0, 'h1F0, 0);
    chk("hold_state_not_early", 32'(bus.data_out), 32'h0);
    drive(0, 0, 'h1F0, 0);
    chk("hold_state_set", 32'(bus.data_out), 32'h1);
    drive(0, 0, 'h1F1, 0);
    chk("edge_set", 32'(bus.data_out), 32'h1);
    drive(0, 1, 'h1F1, 8'h01);
    drive(0, 0, 'h1F1, 0);
    chk("w1c_clear", 32'(bus.data_out), 32'h0);
    buttons = 4'h0;
    for (int k = 0; k < 8; k++) drive(0, 0, 'h1F0, 0);
    buttons = 4'h1;
    for (int k = 0; k < 5; k++) drive(0, 0, 'h1F0, 0);
    drive(0, 1, 'h1F1, 8'h01);
    drive(0, 0, 'h1F1, 0);
    chk("set_wins_over_clear", 32'(bus.data_out), 32'h1);
    if (IRQ_EN) begin
      drive(0, 1, 'h1FE, 8'h01);
      chk("irq_after_mask_write", 32'(irq), 32'h0);
      drive(0, 0, 0, 0);
      chk("irq_asserted", 32'(irq), 32'h1);
      drive(0, 1, 'h1FE, 8'h00);
      chk("irq_still_high", 32'(irq), 32'h1);
      drive(0, 0, 0, 0);
      chk("irq_deasserted", 32'(irq), 32'h0);
    end else begin
      drive(0, 1, 'h1FE, 8'h01);
      drive(0, 0, 'h1FE, 0);
      chk("mask_reserved", 32'(bus.data_out), 32'h0);
    end

    for (int c = 0; c < 4000; c++) begin
      logic r;
      int a;
      r = ($urandom_range(0, 249) == 0);
      a = ($urandom_range(0, 1) == 0) ? IO_BASE + int'($urandom_range(0, 15)) : int'($urandom_range(0, IO_BASE - 1));
      if ($urandom_range(0, 5) == 0) buttons[$urandom_range(0, NB - 1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) switches = NS'($urandom);
      drive(r, r ? 1'b0 : 1'($urandom_range(0, 2) == 0), a, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
